// File: rtl/lab07_pkg.sv
// Shared definitions for the lab07 single-cycle core: opcodes, instruction
// field positions, ALU operation select and immediate sign extension.
package lab07_pkg;

  localparam int XLEN      = 32;
  localparam int NUM_REGS  = 32;
  localparam int NUM_WORDS = 32;

  localparam logic [5:0] OP_ADD = 6'b000001;
  localparam logic [5:0] OP_SUB = 6'b000011;
  localparam logic [5:0] OP_AND = 6'b000101;
  localparam logic [5:0] OP_OR  = 6'b000111;
  localparam logic [5:0] OP_LW  = 6'b000100;
  localparam logic [5:0] OP_SW  = 6'b000010;

  localparam int OPC_HI = 31;
  localparam int OPC_LO = 26;
  localparam int RS_HI  = 25;
  localparam int RS_LO  = 21;
  localparam int RT_HI  = 20;
  localparam int RT_LO  = 16;
  localparam int RD_HI  = 15;
  localparam int RD_LO  = 11;
  localparam int IMM_HI = 15;
  localparam int IMM_LO = 0;

  typedef enum logic [1:0] {
    ALU_ADD = 2'd0,
    ALU_SUB = 2'd1,
    ALU_AND = 2'd2,
    ALU_OR  = 2'd3
  } alu_op_e;

  function automatic logic [XLEN-1:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

endpackage

// File: rtl/lab07_alu.sv
// Combinational ALU: selects add/sub/and/or over two 32-bit operands.
module lab07_alu
  import lab07_pkg::*;
(
  input  alu_op_e          op,
  input  logic [XLEN-1:0]  a,
  input  logic [XLEN-1:0]  b,
  output logic [XLEN-1:0]  y
);

  always_comb begin
    y = a + b;
    case (op)
      ALU_ADD: y = a + b;
      ALU_SUB: y = a - b;
      ALU_AND: y = a & b;
      ALU_OR:  y = a | b;
      default: y = a + b;
    endcase
  end

endmodule

// File: rtl/lab07.sv
// Single-cycle 32-bit core: one instruction per clock, 32x32 register file,
// 32-word data memory, combinational result on OUT.
module lab07
  import lab07_pkg::*;
(
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [XLEN-1:0]  INST,
  output logic [XLEN-1:0]  OUT
);

  logic [XLEN-1:0] regs [NUM_REGS];
  logic [XLEN-1:0] mem  [NUM_WORDS];

  logic [5:0]      opcode;
  logic [4:0]      rs, rt, rd;
  logic [XLEN-1:0] imm_ext;
  logic [XLEN-1:0] rs_val, rt_val;

  logic            is_r, is_lw, is_sw;
  alu_op_e         alu_op;
  logic [XLEN-1:0] alu_b, alu_y;
  logic [4:0]      mem_addr;
  logic [XLEN-1:0] mem_rdata;

  logic            reg_we;
  logic [4:0]      reg_dst;
  logic [XLEN-1:0] reg_wdata;
  logic            mem_we;

  assign opcode  = INST[OPC_HI:OPC_LO];
  assign rs      = INST[RS_HI:RS_LO];
  assign rt      = INST[RT_HI:RT_LO];
  assign rd      = INST[RD_HI:RD_LO];
  assign imm_ext = sext16(INST[IMM_HI:IMM_LO]);

  assign rs_val = (rs == 5'd0) ? '0 : regs[rs];
  assign rt_val = (rt == 5'd0) ? '0 : regs[rt];

  always_comb begin
    is_r   = 1'b0;
    is_lw  = 1'b0;
    is_sw  = 1'b0;
    alu_op = ALU_ADD;
    case (opcode)
      OP_ADD: begin is_r = 1'b1; alu_op = ALU_ADD; end
      OP_SUB: begin is_r = 1'b1; alu_op = ALU_SUB; end
      OP_AND: begin is_r = 1'b1; alu_op = ALU_AND; end
      OP_OR:  begin is_r = 1'b1; alu_op = ALU_OR;  end
      OP_LW:  is_lw = 1'b1;
      OP_SW:  is_sw = 1'b1;
      default: ;
    endcase
  end

  // Loads and stores reuse the ALU adder to form rs + sext(imm).
  assign alu_b = is_r ? rt_val : imm_ext;

  lab07_alu u_alu (
    .op (alu_op),
    .a  (rs_val),
    .b  (alu_b),
    .y  (alu_y)
  );

  assign mem_addr  = alu_y[4:0];
  assign mem_rdata = mem[mem_addr];

  assign reg_dst   = is_r ? rd : rt;
  assign reg_wdata = is_r ? alu_y : mem_rdata;
  assign reg_we    = (is_r || is_lw) && (reg_dst != 5'd0);
  assign mem_we    = is_sw;

  assign OUT = is_r  ? alu_y     :
               is_lw ? mem_rdata :
               is_sw ? rt_val    : '0;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= XLEN'(i);
      end
    end else if (reg_we) begin
      regs[reg_dst] <= reg_wdata;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < NUM_WORDS; i++) begin
        mem[i] <= '0;
      end
    end else if (mem_we) begin
      mem[mem_addr] <= rt_val;
    end
  end

endmodule

// File: tb/tb_lab07.sv
// Bench for lab07: directed program plus random instructions, checked by a
// negedge monitor against a queue filled from an architectural model.
module tb_lab07;

  localparam logic [5:0] K_ADD = 6'b000001;
  localparam logic [5:0] K_SUB = 6'b000011;
  localparam logic [5:0] K_AND = 6'b000101;
  localparam logic [5:0] K_OR  = 6'b000111;
  localparam logic [5:0] K_LW  = 6'b000100;
  localparam logic [5:0] K_SW  = 6'b000010;

  logic        CLK;
  logic        RST_N;
  logic [31:0] INST;
  logic [31:0] OUT;

  lab07 dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .INST  (INST),
    .OUT   (OUT)
  );

  // clock / reset
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // architectural model state
  logic [31:0] m_reg [32];
  logic [31:0] m_mem [32];

  // scoreboard
  logic [31:0] exp_q [$];
  string       name_q [$];
  int          total = 0;
  int          bad   = 0;

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_reg[i] = i;
      m_mem[i] = 0;
    end
  endtask

  task automatic model_exec(input logic [31:0] inst, input bit commit,
                            output logic [31:0] res);
    logic [5:0]  op;
    int          rs, rt, rd, dst, addr;
    logic [31:0] a, b, sx;
    bit          wr_reg;
    op  = inst[31:26];
    rs  = inst[25:21];
    rt  = inst[20:16];
    rd  = inst[15:11];
    a   = m_reg[rs];
    b   = m_reg[rt];
    sx  = {{16{inst[15]}}, inst[15:0]};
    addr = (a + sx) % 32;
    wr_reg = 0;
    dst = rd;
    res = 0;
    case (op)
      K_ADD: begin res = a + b; wr_reg = 1; end
      K_SUB: begin res = a - b; wr_reg = 1; end
      K_AND: begin res = a & b; wr_reg = 1; end
      K_OR:  begin res = a | b; wr_reg = 1; end
      K_LW:  begin res = m_mem[addr]; wr_reg = 1; dst = rt; end
      K_SW:  begin
        res = b;
        if (commit) m_mem[addr] = b;
      end
      default: res = 0;
    endcase
    if (commit && wr_reg && dst != 0) m_reg[dst] = res;
  endtask

  function automatic logic [31:0] enc_r(logic [5:0] op, int rd, int rs, int rt);
    return {op, 5'(rs), 5'(rt), 5'(rd), 11'd0};
  endfunction

  function automatic logic [31:0] enc_i(logic [5:0] op, int rt, int rs, int imm);
    return {op, 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  // driver tasks
  task automatic drive(input logic [31:0] inst, input string nm,
                       input bit use_k, input logic [31:0] k);
    logic [31:0] r;
    @(posedge CLK);
    #1;
    INST = inst;
    model_exec(inst, RST_N, r);
    exp_q.push_back(use_k ? k : r);
    name_q.push_back(nm);
  endtask

  task automatic drv(input logic [31:0] inst, input string nm);
    drive(inst, nm, 1'b0, 32'd0);
  endtask

  task automatic drk(input logic [31:0] inst, input string nm, input logic [31:0] k);
    drive(inst, nm, 1'b1, k);
  endtask

  task automatic do_reset();
    @(posedge CLK);
    #1;
    INST  = 32'd0;
    RST_N = 1'b0;
    model_reset();
    @(negedge CLK);
    #2;
    RST_N = 1'b1;
  endtask

  task automatic release_reset();
    @(negedge CLK);
    #2;
    INST  = 32'd0;
    RST_N = 1'b1;
  endtask

  // monitor: the DUT presents a result every cycle; check it mid-cycle
  always @(negedge CLK) begin
    if (exp_q.size() != 0) begin
      logic [31:0] e;
      string       n;
      e = exp_q.pop_front();
      n = name_q.pop_front();
      total++;
      if (OUT !== e) begin
        bad++;
        $display("FAIL %s: OUT=%h expected=%h", n, OUT, e);
      end
    end
  end

  initial begin
    RST_N = 1'b0;
    INST  = 32'd0;
    model_reset();
    #12;
    RST_N = 1'b1;

    // reset contents visible through rd=$0 observers
    drk(enc_r(K_OR, 0, 31, 0), "reset_reg31", 32'd31);
    drk(enc_i(K_LW, 0, 0, 31), "reset_mem31", 32'd0);

    // same add twice: 3 then 5
    drk(32'h04410800, "add_first", 32'd3);
    drk(32'h04410800, "add_second", 32'd5);
    do_reset();

    drk(enc_r(K_ADD, 1, 2, 3), "seq_add1", 32'd5);
    drk(enc_r(K_ADD, 2, 4, 3), "seq_add2", 32'd7);
    drk(enc_r(K_SUB, 1, 2, 3), "seq_sub", 32'd4);
    drk(enc_i(K_LW, 3, 2, 0), "seq_lw_addr7", 32'd0);
    drk(enc_r(K_OR, 0, 3, 0), "seq_reg3_zero", 32'd0);
    drk(enc_i(K_SW, 2, 1, 0), "seq_sw_addr4", 32'd7);
    drk(enc_i(K_LW, 5, 1, 0), "seq_lw_back", 32'd7);
    drk(enc_i(K_LW, 0, 0, 4), "seq_mem4", 32'd7);

    // reset asserted mid-cycle: contents restored with no edge in between
    @(posedge CLK);
    #1;
    INST  = enc_r(K_OR, 0, 1, 0);
    RST_N = 1'b0;
    model_reset();
    exp_q.push_back(32'd1);
    name_q.push_back("rst_mid_reg1");
    drk(enc_i(K_LW, 0, 0, 4), "rst_mid_mem4", 32'd0);
    drk(enc_r(K_ADD, 9, 2, 3), "rst_hold_add", 32'd5);
    drk(enc_r(K_OR, 0, 9, 0), "rst_hold_nowrite", 32'd9);
    release_reset();

    drk(enc_r(K_AND, 7, 5, 6), "and_5_6", 32'd4);
    drk(enc_r(K_OR, 8, 5, 6), "or_5_6", 32'd7);
    do_reset();
    drk(enc_r(K_SUB, 7, 0, 1), "sub_neg", 32'hFFFF_FFFF);
    drk(enc_r(K_ADD, 0, 5, 6), "write_r0_out", 32'd11);
    drk(enc_r(K_OR, 0, 0, 0), "r0_reads_zero", 32'd0);
    drk(enc_i(K_LW, 0, 0, 0), "lw_to_r0", 32'd0);
    drk(enc_r(K_OR, 0, 0, 0), "r0_after_lw", 32'd0);
    drk({6'b111111, 26'h3FF_FFFF}, "nop_out", 32'd0);
    drk(enc_r(K_OR, 0, 31, 0), "nop_no_change", 32'd31);
    drk(enc_i(K_SW, 31, 0, 16'hFFFF), "sw_wrap_addr31", 32'd31);
    drk(enc_i(K_LW, 0, 2, 16'hFFFD), "lw_wrap_neg", 32'd31);

    // randomized program against the model
    for (int n = 0; n < 400; n++) begin
      logic [5:0]  op;
      int          sel;
      if ($urandom_range(0, 59) == 0) do_reset();
      sel = $urandom_range(0, 7);
      case (sel)
        0: op = K_ADD;
        1: op = K_SUB;
        2: op = K_AND;
        3: op = K_OR;
        4: op = K_LW;
        5: op = K_SW;
        6: op = K_LW;
        default: begin
          op = 6'($urandom_range(0, 63));
          if (op inside {K_ADD, K_SUB, K_AND, K_OR, K_LW, K_SW}) op = 6'b111111;
        end
      endcase
      drv({op, 26'($urandom)}, "random");
    end

    @(negedge CLK);
    #1;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: pending=%0d expected=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lab07.md
# lab07

Single-cycle 32-bit processor core that executes one externally supplied instruction per clock. It holds a 32×32 register file and a 32-word data memory. It exposes the result of the current instruction combinationally on `OUT`. It is the top level of the lab datapath; instructions come straight from the bench or an instruction ROM.

## Interface
- No parameters (width 32, 32 registers, 32 memory words are fixed).
- `CLK` input, 1 bit. Single clock; all state updates on the rising edge.
- `RST_N` input, 1 bit. Reset is asynchronous and active-low.
- `INST` input, 32 bits. Current instruction, held stable across the rising edge.
- `OUT` output, 32 bits. Combinational result of the current instruction.

## Operation
- Fields:
  - opcode = `INST[31:26]`
  - rs = `INST[25:21]`
  - rt = `INST[20:16]`
  - rd = `INST[15:11]`
  - imm = `INST[15:0]`, sign-extended to 32 bits
- Opcodes:
  - 000001 ADD (R-type): rd ← rs + rt.
  - 000011 SUB (R-type): rd ← rs − rt.
  - 000101 AND (R-type): rd ← rs & rt.
  - 000111 OR (R-type): rd ← rs | rt.
  - 000100 LW (I-type): rt ← mem[addr].
  - 000010 SW (I-type): mem[addr] ← rt.
  - Any other opcode is a NOP: no register or memory write, `OUT` = 0.
- Address: addr = (rs + sext(imm))[4:0], a word index that wraps modulo 32.
- Arithmetic: 32-bit two's-complement, wrap-around, no overflow flag. `INST[10:0]` is ignored for R-type.
- `OUT`:
  - R-type: the ALU result.
  - LW: the memory read data.
  - SW: the store data (value of rt).
  - NOP: 0.
- Register 0 reads as 0; writes to it are discarded.
- Register reads and memory reads are combinational.
- Reset:
  - Register i resets to i, so reg0 = 0 … reg31 = 31.
  - All memory words reset to 0.
  - `OUT` follows the reset state combinationally.

## Timing
- `OUT` is valid combinationally after `INST` or state changes, with zero-cycle latency. It is not registered.
- Register and memory writes commit on the rising `CLK` edge while `RST_N` = 1.
- After the edge, `OUT` recomputes with the updated state. For example, `add $1,$2,$1` applied for two cycles shows 3, then 5.
- Read-before-write within a cycle: sources use pre-edge values, including when rd = rs or rt.
- `RST_N` low mid-cycle immediately restores the reset contents and blocks writes. A write edge coincident with reset deassertion is suppressed.

## Structure
- Shared package `lab07_pkg`: opcode localparams (OP_ADD, OP_SUB, OP_AND, OP_OR, OP_LW, OP_SW) and the field bit positions.
- One natural sub-module, `lab07_alu`: combinational op select plus two 32-bit operands to a 32-bit result.
- Register file and data memory live in the top as arrays with asynchronous reset.

## Test plan
- Reset, then `add $1,$2,$1` = 32'h04410800 → `OUT` = 3 before the edge; after the edge reg1 = 3.
- Sequence, each instruction held for one clock, starting from reset state:
  - `add $1,$2,$3` → `OUT` = 5.
  - `add $2,$4,$3` → `OUT` = 7.
  - `sub $1,$2,$3` → `OUT` = 4.
- Continuing the sequence:
  - `lw $3,0($2)` (addr 7) → `OUT` = 0, reg3 = 0.
  - `sw $2,0($1)` (addr 4) → `OUT` = 7, mem[4] = 7.
  - `lw $5,0($1)` → `OUT` = 7.
- `and` and `or` with reg5 = 5 and reg6 = 6 → `OUT` = 4 and 7 respectively.
- `sub $7,$0,$1` with reg1 = 1 → `OUT` = 32'hFFFFFFFF.
- Writes to $0 leave it reading 0.
- Unknown opcode 6'b111111 → `OUT` = 0 and no state change.
- Assert `RST_N` low mid-sequence → registers return to i and memory to 0 immediately, without waiting for an edge.
